adbus_arbiter: RTL and testbench

//  Shares the 32-bit bidirectional AD pad bus between NREQ internal requesters.

---
 rtl/adbus_pkg.sv | 38 +++
 rtl/adbus_rr_pick.sv | 29 ++
 rtl/adbus_arbiter.sv | 144 ++++++++++++++
 tb/tb_adbus_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adbus_pkg.sv
// Shared types and the round-robin selection rule for the AD bus arbiter.
// rr_pick works on a widest-case request vector so any NREQ up to 8 can reuse it.
package adbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TURN = 2'd2
  } state_t;

  localparam int NREQ_MAX  = 8;
  localparam int IDX_MAX_W = 3;

  typedef struct packed {
    logic                 found;
    logic [IDX_MAX_W-1:0] idx;
  } pick_t;

  // First requester at or after ptr, wrapping within the nreq live requesters.
  function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0]  req,
                                    input logic [IDX_MAX_W-1:0] ptr,
                                    input int                   nreq);
    pick_t res;
    int    k;
    res = '0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      if (i < nreq) begin
        k = (int'(ptr) + i) % nreq;
        if (!res.found && req[k]) begin
          res.found = 1'b1;
          res.idx   = IDX_MAX_W'(k);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/adbus_rr_pick.sv
// Combinational round-robin priority encoder: returns the first active request
// at or after ptr, plus a valid flag when any request is present.
module adbus_rr_pick
  import adbus_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  idx,
  output logic            valid
);

  pick_t                pick;
  logic [NREQ_MAX-1:0]  req_ext;
  logic [IDX_MAX_W-1:0] ptr_ext;

  assign req_ext = NREQ_MAX'(req);
  assign ptr_ext = IDX_MAX_W'(ptr);

  always_comb begin
    pick = rr_pick(req_ext, ptr_ext, NREQ);
  end

  assign idx   = IDW'(pick.idx);
  assign valid = pick.found;

endmodule

// File: rtl/adbus_arbiter.sv
// Round-robin owner of the shared AD pad bus: grants bursts, limits beats,
// registers pad drive/capture and enforces idle turnaround after writes.
module adbus_arbiter
  import adbus_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DW         = 32,
  parameter int TURNAROUND = 1,
  parameter int MAX_BURST  = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          Req,
  input  logic [NREQ-1:0]          Dir,
  input  logic [NREQ*DW-1:0]       WData,
  input  logic [DW-1:0]            ADIn,
  output logic [NREQ-1:0]          Gnt,
  output logic [NREQ-1:0]          Ack,
  output logic [DW-1:0]            ADOut,
  output logic                     DriveEn,
  output logic [DW-1:0]            RData,
  output logic                     RValid,
  output logic [$clog2(NREQ)-1:0]  RId,
  output logic                     Busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  state_t          state, state_n;
  logic [NREQ-1:0] gnt_q, gnt_n;
  logic [IDW-1:0]  owner_q, owner_n;
  logic [IDW-1:0]  ptr_q, ptr_n;
  logic            dir_q, dir_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [1:0]      tcnt_q, tcnt_n;
  logic [IDW-1:0]  pick_idx;
  logic            pick_valid;
  logic            beat;

  adbus_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (Req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign Ack  = (state == XFER) ? (gnt_q & Req) : '0;
  assign beat = |Ack;
  assign Gnt  = gnt_q;
  assign Busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state   <= state_n;
      gnt_q   <= gnt_n;
      owner_q <= owner_n;
      ptr_q   <= ptr_n;
      dir_q   <= dir_n;
      cnt_q   <= cnt_n;
      tcnt_q  <= tcnt_n;
    end
  end

  // A burst ends on the owner's first idle cycle or on its last permitted beat.
  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    owner_n = owner_q;
    ptr_n   = ptr_q;
    dir_n   = dir_q;
    cnt_n   = cnt_q;
    tcnt_n  = tcnt_q;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = XFER;
          gnt_n   = NREQ'(1) << pick_idx;
          owner_n = pick_idx;
          dir_n   = Dir[pick_idx];
          cnt_n   = '0;
        end
      end
      XFER: begin
        if (!beat || (cnt_q == CW'(MAX_BURST - 1))) begin
          gnt_n   = '0;
          cnt_n   = '0;
          tcnt_n  = '0;
          ptr_n   = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);
          state_n = (dir_q && (TURNAROUND > 0)) ? TURN : IDLE;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      TURN: begin
        if (tcnt_q == 2'(TURNAROUND)) begin
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt_q + 2'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // ADOut keeps its last driven value so the pad sees no glitch when DriveEn drops.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ADOut   <= '0;
      DriveEn <= 1'b0;
      RData   <= '0;
      RValid  <= 1'b0;
      RId     <= '0;
    end else begin
      if (beat && dir_q) begin
        ADOut   <= WData[int'(owner_q)*DW +: DW];
        DriveEn <= 1'b1;
      end else begin
        DriveEn <= 1'b0;
      end
      if (beat && !dir_q) begin
        RData  <= ADIn;
        RValid <= 1'b1;
        RId    <= owner_q;
      end else begin
        RValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adbus_arbiter.sv
// Directed plus randomized bench for adbus_arbiter; every cycle is compared
// against a transaction-level reference model of the arbitration rules.
module tb_adbus_arbiter;

  localparam int NREQ       = 4;
  localparam int DW         = 32;
  localparam int TURNAROUND = 1;
  localparam int MAX_BURST  = 16;

  logic              Clk;
  logic              Reset;
  logic [NREQ-1:0]   Req, Dir, Gnt, Ack;
  logic [NREQ*DW-1:0] WData;
  logic [DW-1:0]     ADIn, ADOut, RData;
  logic              DriveEn, RValid, Busy;
  logic [1:0]        RId;

  adbus_arbiter #(
    .NREQ       (NREQ),
    .DW         (DW),
    .TURNAROUND (TURNAROUND),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Req     (Req),
    .Dir     (Dir),
    .WData   (WData),
    .ADIn    (ADIn),
    .Gnt     (Gnt),
    .Ack     (Ack),
    .ADOut   (ADOut),
    .DriveEn (DriveEn),
    .RData   (RData),
    .RValid  (RValid),
    .RId     (RId),
    .Busy    (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: owner (-1 = none), beats taken, quiet cycles left after a write.
  bit          m_valid   = 1'b0;
  int          m_owner   = -1;
  bit          m_dir     = 1'b0;
  int          m_beats   = 0;
  int          m_ptr     = 0;
  int          m_quiet   = 0;
  int          m_ack_idx = -1;
  logic [31:0] e_adout   = '0;
  logic [31:0] e_rdata   = '0;
  bit          e_driveen = 1'b0;
  bit          e_rvalid  = 1'b0;
  int          e_rid     = 0;
  logic [3:0]  obs_ack   = '0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] e_gnt, e_ack;
    obs_ack = Ack;
    if (m_valid) begin
      e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
      e_ack = (m_owner >= 0 && Req[m_owner]) ? e_gnt : 4'h0;
      checkEq("gnt",     32'(Gnt),     32'(e_gnt));
      checkEq("ack",     32'(Ack),     32'(e_ack));
      checkEq("driveen", 32'(DriveEn), 32'(e_driveen));
      checkEq("adout",   ADOut,        e_adout);
      checkEq("rvalid",  32'(RValid),  32'(e_rvalid));
      checkEq("rdata",   RData,        e_rdata);
      checkEq("rid",     32'(RId),     32'(e_rid));
      checkEq("busy",    32'(Busy),    32'((m_owner >= 0) || (m_quiet > 0)));
    end
  endtask

  task automatic modelStep();
    bit hit;
    bit found;
    int c;
    m_ack_idx = -1;
    if (!Reset) begin
      m_valid = 1'b1; m_owner = -1; m_dir = 1'b0; m_beats = 0; m_ptr = 0; m_quiet = 0;
      e_adout = '0; e_rdata = '0; e_driveen = 1'b0; e_rvalid = 1'b0; e_rid = 0;
      return;
    end
    hit = (m_owner >= 0) && Req[m_owner];
    e_driveen = hit && m_dir;
    e_rvalid  = hit && !m_dir;
    if (hit) begin
      m_ack_idx = m_owner;
      if (m_dir) e_adout = WData[m_owner*DW +: DW];
      else begin
        e_rdata = ADIn;
        e_rid   = m_owner;
      end
    end
    if (m_owner >= 0) begin
      if (hit) m_beats++;
      if (!hit || m_beats == MAX_BURST) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_quiet = (m_dir && TURNAROUND > 0) ? TURNAROUND + 1 : 0;
        m_owner = -1;
        m_beats = 0;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (!found && Req[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_dir   = Dir[c];
          m_beats = 0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] req, input logic [3:0] dir);
    Reset = rst;
    Req   = req;
    Dir   = dir;
    @(negedge Clk);
    checkOutput();
    modelStep();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          order[$];
    logic [3:0]  prev_gnt;
    logic [3:0]  drop;
    int          nack, gap;
    bit          was_granted, dropped, regranted;
    int          oi;

    Reset = 1'b0; Req = '0; Dir = '0; WData = '0; ADIn = '0;
    @(posedge Clk);
    #1;

    // Reset held with all requests active.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'hF, 4'h0);
    checkEq("rst_gnt",     32'(Gnt),     32'h0);
    checkEq("rst_driveen", 32'(DriveEn), 32'h0);
    checkEq("rst_busy",    32'(Busy),    32'h0);

    // Single write burst of three beats by requester 2.
    WData[2*DW +: DW] = 32'hA5A5_0001;
    applyStimulus(1'b1, 4'b0100, 4'b0100);
    checkEq("wr_gnt", 32'(Gnt), 32'h4);
    for (int b = 1; b <= 3; b++) begin
      WData[2*DW +: DW] = 32'hA5A5_0000 + 32'(b);
      applyStimulus(1'b1, 4'b0100, 4'b0100);
      checkEq("wr_adout",   ADOut,         32'hA5A5_0000 + 32'(b));
      checkEq("wr_driveen", 32'(DriveEn),  32'h1);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'h0, 4'h0);
    checkEq("wr_after_drive", 32'(DriveEn), 32'h0);

    // Single read beat by requester 0.
    ADIn = 32'h1234_5678;
    applyStimulus(1'b1, 4'b0001, 4'b0000);
    applyStimulus(1'b1, 4'b0001, 4'b0000);
    checkEq("rd_rdata",   RData,        32'h1234_5678);
    checkEq("rd_rvalid",  32'(RValid),  32'h1);
    checkEq("rd_rid",     32'(RId),     32'h0);
    checkEq("rd_driveen", 32'(DriveEn), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'h0, 4'h0);

    // Round-robin: everyone requests, each drops for one cycle after its beat.
    applyStimulus(1'b0, 4'h0, 4'h0);
    drop = '0;
    prev_gnt = '0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 4'hF & ~drop, 4'h0);
      drop = (m_ack_idx >= 0) ? 4'(1 << m_ack_idx) : 4'h0;
      if (Gnt != 4'h0 && Gnt != prev_gnt) begin
        for (int k = 0; k < NREQ; k++) if (Gnt[k]) order.push_back(k);
      end
      prev_gnt = Gnt;
    end
    for (int i = 0; i < 5; i++) begin
      oi = (i < order.size()) ? order[i] : -1;
      checkEq("rr_order", 32'(oi), 32'((i == 4) ? 0 : i));
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'h0, 4'h0);

    // Burst limit with requester 1 holding its request.
    nack = 0; gap = 0; was_granted = 0; dropped = 0; regranted = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 4'b0010, 4'b0000);
      if (!dropped && obs_ack[1]) nack++;
      if (!dropped && Gnt == 4'b0010) was_granted = 1'b1;
      else if (!dropped && was_granted && Gnt == 4'h0) dropped = 1'b1;
      if (dropped && !regranted) begin
        if (Gnt == 4'h0) gap++;
        else if (Gnt == 4'b0010) regranted = 1'b1;
      end
    end
    checkEq("limit_acks",    32'(nack),      32'(MAX_BURST));
    checkEq("limit_gap",     32'(gap >= 1),  32'h1);
    checkEq("limit_regrant", 32'(regranted), 32'h1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'h0, 4'h0);

    // Reset during the fifth beat of a write burst by requester 3.
    WData[3*DW +: DW] = 32'hC0DE_0000;
    applyStimulus(1'b1, 4'b1000, 4'b1000);
    for (int b = 1; b <= 5; b++) begin
      WData[3*DW +: DW] = 32'hC0DE_0000 + 32'(b);
      applyStimulus((b == 5) ? 1'b0 : 1'b1, 4'b1000, 4'b1000);
    end
    checkEq("mid_rst_driveen", 32'(DriveEn), 32'h0);
    checkEq("mid_rst_gnt",     32'(Gnt),     32'h0);
    checkEq("mid_rst_busy",    32'(Busy),    32'h0);
    applyStimulus(1'b1, 4'b1000, 4'b1000);
    checkEq("mid_rst_regrant", 32'(Gnt), 32'h8);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'h0, 4'h0);

    // Randomized traffic with sticky requests and rare resets.
    begin
      logic [3:0] rq, dr;
      rq = '0;
      for (int i = 0; i < 600; i++) begin
        for (int k = 0; k < NREQ; k++) begin
          if ($urandom_range(0, 5) == 0) rq[k] = ~rq[k];
          WData[k*DW +: DW] = $urandom;
        end
        dr   = 4'($urandom);
        ADIn = $urandom;
        applyStimulus(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1, rq, dr);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
